vga_text_timing: RTL and testbench
==================================

VGA_TEXT_TIMING -- requirements
Module: vga_text_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48: horizontal porch and sync widths, in pixels.
REQ-003 SHALL have parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33: vertical timing, in lines.
REQ-004 SHALL have parameters H_POL, V_POL, default 0: sync active level (0 = active-low).
REQ-005 SHALL have parameter CLK_DIV, default 4: CLK cycles per pixel, minimum 1.
REQ-006 SHALL have parameters CHAR_W, CHAR_H, defaults 8, 16: glyph cell size; each SHALL be a power of two.
REQ-007 SHALL have parameter COLOR_BITS, default 4: bits per colour channel.
REQ-008 SHALL have parameter PIPE_DLY, default 2, range 0..7: pixel delay of the upstream font/colour path.
REQ-009 SHALL have port CLK  in  1: system clock; one clock domain only.
REQ-010 SHALL have port RST_BTN  in  1: asynchronous, active-low reset.
REQ-011 SHALL have port EN  in  1: timing enable.
REQ-012 SHALL have ports PIX_R, PIX_G, PIX_B  in  COLOR_BITS each: upstream colour, valid PIPE_DLY pixels after its coordinates.
REQ-013 SHALL have ports VGA_HS_O, VGA_VS_O  out  1: sync outputs, registered.
REQ-014 SHALL have ports VGA_R, VGA_G, VGA_B  out  COLOR_BITS each: blanked colour outputs, registered.
REQ-015 SHALL have ports PIX_X, PIX_Y  out  clog2(H_TOTAL), clog2(V_TOTAL): current counter position.
REQ-016 SHALL have ports CHAR_COL, CHAR_ROW, GLYPH_X, GLYPH_Y  out  sized to match: character-cell decode of PIX_X/PIX_Y.
REQ-017 SHALL have ports ACTIVE, PIX_STB, LINE_START, FRAME_START  out  1 each: status strobes.

Function
REQ-018 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL be the vertical equivalent.
REQ-019 A divider SHALL count 0..CLK_DIV-1, and PIX_STB SHALL be high for one CLK when the divider is at CLK_DIV-1.
REQ-020 On PIX_STB, PIX_X SHALL increment and wrap from H_TOTAL-1 to 0; on that wrap, PIX_Y SHALL increment and wrap from V_TOTAL-1 to 0.
REQ-021 ACTIVE SHALL be (PIX_X<H_ACTIVE && PIX_Y<V_ACTIVE), undelayed.
REQ-022 Raw hsync SHALL be asserted for PIX_X in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], and raw vsync likewise on PIX_Y; each output SHALL be driven at its POL level when asserted.
REQ-023 CHAR_COL SHALL be PIX_X/CHAR_W, GLYPH_X SHALL be PIX_X%CHAR_W, and CHAR_ROW/GLYPH_Y SHALL be the same on PIX_Y, all by bit slicing.
REQ-024 LINE_START SHALL be PIX_STB && PIX_X==0, and FRAME_START SHALL be PIX_STB && PIX_X==0 && PIX_Y==0.
REQ-025 Raw hsync, raw vsync and ACTIVE SHALL be delayed PIPE_DLY pixel strobes by a shift register advanced only on PIX_STB.
REQ-026 On PIX_STB, VGA_R/G/B SHALL register PIX_R/G/B when delayed ACTIVE is 1, else 0; VGA_HS_O/VGA_VS_O SHALL register the delayed syncs.
REQ-027 Total latency from counter position to VGA pins SHALL be PIPE_DLY+1 pixels, identical for sync and colour.
REQ-028 When EN=0, the divider, PIX_X, PIX_Y and the delay line SHALL clear synchronously; syncs SHALL be inactive, colour 0, and strobes 0.
REQ-029 On EN returning to 1, the first PIX_STB SHALL coincide with FRAME_START at (0,0).
REQ-030 With CLK_DIV=1, PIX_STB SHALL be held at constant 1.

Reset
REQ-031 While RST_BTN=0, all counters, the delay line and the colour outputs SHALL be 0, syncs SHALL be at their inactive level, and strobes SHALL be 0.
REQ-032 Reset SHALL be asynchronous assertion with synchronous release; operation after release SHALL be identical to REQ-029, including after assertion mid-line.

Structure
REQ-033 A shared package vga_pkg SHALL hold the 640x480 timing constants, a clog2 function and the polarity encodings.
REQ-034 The design SHALL contain one sub-module, vga_sync_delay: a parametrised-depth, enabled shift register for {hs, vs, active}.
REQ-035 Non-power-of-two CHAR_W/CHAR_H, CLK_DIV=0 or PIPE_DLY>7 SHALL stop elaboration with an error.

Verification (CLK 10 ns, defaults)
REQ-036 Hold RST_BTN=0 for 100 ns -> HS=VS=1, RGB=0, PIX_X=PIX_Y=0, no strobes.
REQ-037 After release, HS SHALL fall (656+2)*4 CLK after the first PIX_STB, stay low 384 CLK, and have a period of 3200 CLK.
REQ-038 VS SHALL be low for 6400 CLK with a frame period of 1,680,000 CLK, and FRAME_START SHALL pulse exactly once per frame.
REQ-039 PIX_R=4'hF held -> VGA_R=F on exactly 640 pixels per visible line, 0 on the other 160 and on lines 480..524.
REQ-040 PIX_X=637, PIX_Y=479 -> CHAR_COL=79, GLYPH_X=5, CHAR_ROW=29, GLYPH_Y=15.
REQ-041 EN=0 at PIX_X=300 -> next CLK counters 0, syncs inactive; EN=1 -> first PIX_STB has FRAME_START=1.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, sync polarity encodings and a constant-safe clog2.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned POL_LOW  = 0;
  localparam int unsigned POL_HIGH = 1;

  // Payload carried through the pixel delay line.
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } sync_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Pixel-strobe-advanced shift register that aligns sync/active with the colour path.
module vga_sync_delay #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    logic unused;
    assign unused = ^{clk, rst_n, clr, adv};
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] sr_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else if (clr) begin
        for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else if (adv) begin
        sr_q[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
    end

    assign q = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_text_timing.sv
// VGA raster timing with character-cell decode and a delay-matched, registered pin stage.
module vga_text_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
  parameter int unsigned H_FP       = VGA_H_FP,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BP       = VGA_H_BP,
  parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
  parameter int unsigned V_FP       = VGA_V_FP,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BP       = VGA_V_BP,
  parameter int unsigned H_POL      = POL_LOW,
  parameter int unsigned V_POL      = POL_LOW,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned CHAR_W     = 8,
  parameter int unsigned CHAR_H     = 16,
  parameter int unsigned COLOR_BITS = 4,
  parameter int unsigned PIPE_DLY   = 2,
  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned XW        = clog2(H_TOTAL),
  localparam int unsigned YW        = clog2(V_TOTAL),
  localparam int unsigned CWB       = clog2(CHAR_W),
  localparam int unsigned CHB       = clog2(CHAR_H)
) (
  input  logic                  CLK,
  input  logic                  RST_BTN,
  input  logic                  EN,
  input  logic [COLOR_BITS-1:0] PIX_R,
  input  logic [COLOR_BITS-1:0] PIX_G,
  input  logic [COLOR_BITS-1:0] PIX_B,
  output logic                  VGA_HS_O,
  output logic                  VGA_VS_O,
  output logic [COLOR_BITS-1:0] VGA_R,
  output logic [COLOR_BITS-1:0] VGA_G,
  output logic [COLOR_BITS-1:0] VGA_B,
  output logic [XW-1:0]         PIX_X,
  output logic [YW-1:0]         PIX_Y,
  output logic [XW-CWB-1:0]     CHAR_COL,
  output logic [YW-CHB-1:0]     CHAR_ROW,
  output logic [CWB-1:0]        GLYPH_X,
  output logic [CHB-1:0]        GLYPH_Y,
  output logic                  ACTIVE,
  output logic                  PIX_STB,
  output logic                  LINE_START,
  output logic                  FRAME_START
);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_text_timing: CLK_DIV must be at least 1");
  end
  if (!is_pow2(CHAR_W) || CHAR_W < 2 || !is_pow2(CHAR_H) || CHAR_H < 2) begin : g_bad_char
    $error("vga_text_timing: CHAR_W and CHAR_H must be powers of two");
  end
  if (PIPE_DLY > 7) begin : g_bad_dly
    $error("vga_text_timing: PIPE_DLY must be in 0..7");
  end

  localparam int unsigned DW = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DivLast  = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] XLast    = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] XActive  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HsStart  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HsEnd    = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] YLast    = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] YActive  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VsStart  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VsEnd    = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HsOn     = (H_POL != POL_LOW);
  localparam logic          VsOn     = (V_POL != POL_LOW);

  // Reset asserts immediately but releases two clocks later, in step with CLK.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [DW-1:0] div_q, div_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          pix_stb;

  assign pix_stb = rst_n & EN & (div_q == DivLast);

  always_comb begin
    div_d = (div_q == DivLast) ? '0 : div_q + DW'(1);
    x_d   = x_q;
    y_d   = y_q;
    if (pix_stb) begin
      if (x_q == XLast) begin
        x_d = '0;
        y_d = (y_q == YLast) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else if (!EN) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  sync_t raw_sync, dly_sync;
  logic  clr;

  always_comb begin
    raw_sync.hs     = (x_q >= HsStart) && (x_q < HsEnd);
    raw_sync.vs     = (y_q >= VsStart) && (y_q < VsEnd);
    raw_sync.active = rst_n && EN && (x_q < XActive) && (y_q < YActive);
  end

  assign clr = ~EN;

  vga_sync_delay #(
    .DEPTH (PIPE_DLY),
    .WIDTH ($bits(sync_t))
  ) u_sync_delay (
    .clk   (CLK),
    .rst_n (rst_n),
    .clr   (clr),
    .adv   (pix_stb),
    .d     (raw_sync),
    .q     (dly_sync)
  );

  logic                  hs_q, vs_q;
  logic [COLOR_BITS-1:0] r_q, g_q, b_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= ~HsOn;
      vs_q <= ~VsOn;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else if (!EN) begin
      hs_q <= ~HsOn;
      vs_q <= ~VsOn;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else if (pix_stb) begin
      hs_q <= dly_sync.hs ? HsOn : ~HsOn;
      vs_q <= dly_sync.vs ? VsOn : ~VsOn;
      r_q  <= dly_sync.active ? PIX_R : '0;
      g_q  <= dly_sync.active ? PIX_G : '0;
      b_q  <= dly_sync.active ? PIX_B : '0;
    end
  end

  assign VGA_HS_O    = hs_q;
  assign VGA_VS_O    = vs_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign PIX_X       = x_q;
  assign PIX_Y       = y_q;
  assign CHAR_COL    = x_q[XW-1:CWB];
  assign GLYPH_X     = x_q[CWB-1:0];
  assign CHAR_ROW    = y_q[YW-1:CHB];
  assign GLYPH_Y     = y_q[CHB-1:0];
  assign ACTIVE      = raw_sync.active;
  assign PIX_STB     = pix_stb;
  assign LINE_START  = pix_stb & (x_q == '0);
  assign FRAME_START = pix_stb & (x_q == '0) & (y_q == '0);

endmodule

// File: tb/tb_vga_text_timing.sv
// Directed bench: a default 640x480 instance plus a narrow-line instance for frame-level timing.
module tb_vga_text_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_btn;
  int   checks = 0;
  int   errors = 0;

  // Instance A: all defaults.
  logic       en_a;
  logic [3:0] pr_a, pg_a, pb_a;
  logic       hs_a, vs_a, act_a, stb_a, ls_a, fs_a;
  logic [3:0] r_a, g_a, b_a;
  logic [9:0] x_a, y_a;
  logic [6:0] ccol_a;
  logic [5:0] crow_a;
  logic [2:0] gx_a;
  logic [3:0] gy_a;

  vga_text_timing u_dut_a (
    .CLK(clk), .RST_BTN(rst_btn), .EN(en_a),
    .PIX_R(pr_a), .PIX_G(pg_a), .PIX_B(pb_a),
    .VGA_HS_O(hs_a), .VGA_VS_O(vs_a), .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a),
    .PIX_X(x_a), .PIX_Y(y_a), .CHAR_COL(ccol_a), .CHAR_ROW(crow_a),
    .GLYPH_X(gx_a), .GLYPH_Y(gy_a), .ACTIVE(act_a), .PIX_STB(stb_a),
    .LINE_START(ls_a), .FRAME_START(fs_a)
  );

  // Instance B: 11-pixel lines, one clock per pixel, default vertical timing.
  logic       en_b;
  logic [3:0] pr_b, pg_b, pb_b;
  logic       hs_b, vs_b, act_b, stb_b, ls_b, fs_b;
  logic [3:0] r_b, g_b, b_b;
  logic [3:0] x_b;
  logic [9:0] y_b;
  logic [0:0] ccol_b;
  logic [5:0] crow_b;
  logic [2:0] gx_b;
  logic [3:0] gy_b;

  vga_text_timing #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1), .CLK_DIV(1)
  ) u_dut_b (
    .CLK(clk), .RST_BTN(rst_btn), .EN(en_b),
    .PIX_R(pr_b), .PIX_G(pg_b), .PIX_B(pb_b),
    .VGA_HS_O(hs_b), .VGA_VS_O(vs_b), .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b),
    .PIX_X(x_b), .PIX_Y(y_b), .CHAR_COL(ccol_b), .CHAR_ROW(crow_b),
    .GLYPH_X(gx_b), .GLYPH_Y(gy_b), .ACTIVE(act_b), .PIX_STB(stb_b),
    .LINE_START(ls_b), .FRAME_START(fs_b)
  );

  task automatic test_reset();
    rst_btn = 1'b0;
    en_a = 1'b1; en_b = 1'b1;
    pr_a = 4'hF; pg_a = 4'h0; pb_a = 4'hA;
    pr_b = 4'hF; pg_b = 4'h0; pb_b = 4'h0;
    #100;
    @(negedge clk);
    checks++;
    if ({hs_a, vs_a} !== 2'b11) begin
      errors++; $display("FAIL reset_sync got=%b%b want=11", hs_a, vs_a);
    end
    checks++;
    if ({r_a, g_a, b_a} !== 12'h000) begin
      errors++; $display("FAIL reset_rgb got=%h%h%h want=000", r_a, g_a, b_a);
    end
    checks++;
    if (x_a !== 10'd0 || y_a !== 10'd0) begin
      errors++; $display("FAIL reset_xy got=%0d,%0d want=0,0", x_a, y_a);
    end
    checks++;
    if ({stb_a, ls_a, fs_a, stb_b} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got=%b%b%b%b want=0000", stb_a, ls_a, fs_a, stb_b);
    end
  endtask

  task automatic test_first_strobe();
    int n;
    rst_btn = 1'b1;
    n = 0;
    while (!stb_a && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (stb_a !== 1'b1) begin
      errors++; $display("FAIL first_stb timeout got=%b want=1", stb_a);
    end
    checks++;
    if (fs_a !== 1'b1 || ls_a !== 1'b1) begin
      errors++; $display("FAIL first_stb_frame got fs=%b ls=%b want 1 1", fs_a, ls_a);
    end
    checks++;
    if (x_a !== 10'd0 || y_a !== 10'd0) begin
      errors++; $display("FAIL first_stb_xy got=%0d,%0d want=0,0", x_a, y_a);
    end
  endtask

  // Entered at the negedge inside the first pixel strobe; posedge n=1 is that strobe's edge.
  task automatic test_hsync();
    int n, m, h;
    n = 0;
    while (n < 4000) begin
      @(posedge clk); #1; n++;
      if (!hs_a) break;
    end
    checks++;
    if (n !== 1 + (656 + 2) * 4) begin
      errors++; $display("FAIL hs_fall got=%0d want=%0d", n, 1 + (656 + 2) * 4);
    end
    m = 0;
    while (m < 1000) begin
      @(posedge clk); #1; m++;
      if (hs_a) break;
    end
    checks++;
    if (m !== 384) begin
      errors++; $display("FAIL hs_low got=%0d want=384", m);
    end
    h = 0;
    while (h < 4000) begin
      @(posedge clk); #1; h++;
      if (!hs_a) break;
    end
    checks++;
    if (m + h !== 3200) begin
      errors++; $display("FAIL hs_period got=%0d want=3200", m + h);
    end
  endtask

  task automatic test_colour_line();
    int n, guard, cnt_r, cnt_rz, cnt_b, cnt_g;
    n = 0;
    @(negedge clk);
    while (!ls_a && n < 3300) begin @(negedge clk); n++; end
    cnt_r = 0; cnt_rz = 0; cnt_b = 0; cnt_g = 0;
    for (int i = 0; i < 800; i++) begin
      guard = 0;
      while (!stb_a && guard < 8) begin @(negedge clk); guard++; end
      if (r_a === 4'hF) cnt_r++;
      if (r_a === 4'h0) cnt_rz++;
      if (b_a === 4'hA) cnt_b++;
      if (g_a !== 4'h0) cnt_g++;
      @(negedge clk);
    end
    checks++;
    if (cnt_r !== 640 || cnt_rz !== 160) begin
      errors++; $display("FAIL line_red got on=%0d off=%0d want 640 160", cnt_r, cnt_rz);
    end
    checks++;
    if (cnt_b !== 640 || cnt_g !== 0) begin
      errors++; $display("FAIL line_blue_green got b=%0d g=%0d want 640 0", cnt_b, cnt_g);
    end
  endtask

  task automatic test_decode_a();
    int n;
    n = 0;
    while (x_a !== 10'd637 && n < 3300) begin @(negedge clk); n++; end
    checks++;
    if (ccol_a !== 7'd79 || gx_a !== 3'd5) begin
      errors++; $display("FAIL decode_x637 got col=%0d gx=%0d want 79 5", ccol_a, gx_a);
    end
    checks++;
    if (act_a !== 1'b1) begin
      errors++; $display("FAIL active_x637 got=%b want=1", act_a);
    end
  endtask

  // Drops EN when PIX_X reaches xstop; pins then show pixel xstop-3 of line 0 of a fresh frame.
  task automatic test_enable(input int xstop);
    int n;
    logic exp_hs;
    logic [3:0] exp_r;
    n = 0;
    while (x_a !== 10'(xstop) && n < 3300) begin @(negedge clk); n++; end
    exp_hs = !((xstop - 3) >= 656 && (xstop - 3) < 752);
    exp_r  = ((xstop - 3) < 640) ? 4'hF : 4'h0;
    checks++;
    if (hs_a !== exp_hs || r_a !== exp_r) begin
      errors++; $display("FAIL en_pre x=%0d got hs=%b r=%h want %b %h", xstop, hs_a, r_a, exp_hs, exp_r);
    end
    en_a = 1'b0;
    #1;
    checks++;
    if ({stb_a, ls_a, fs_a, act_a} !== 4'b0000) begin
      errors++; $display("FAIL en_off_strobes got=%b%b%b%b want=0000", stb_a, ls_a, fs_a, act_a);
    end
    @(posedge clk); #1;
    checks++;
    if (x_a !== 10'd0 || y_a !== 10'd0) begin
      errors++; $display("FAIL en_off_xy got=%0d,%0d want=0,0", x_a, y_a);
    end
    checks++;
    if (hs_a !== 1'b1 || vs_a !== 1'b1 || r_a !== 4'h0 || b_a !== 4'h0) begin
      errors++; $display("FAIL en_off_pins got hs=%b vs=%b r=%h b=%h want 1 1 0 0", hs_a, vs_a, r_a, b_a);
    end
    repeat (5) @(negedge clk);
    en_a = 1'b1;
    n = 0;
    while (!stb_a && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (n !== 3 || fs_a !== 1'b1) begin
      errors++; $display("FAIL en_restart got wait=%0d fs=%b want 3 1", n, fs_a);
    end
  endtask

  task automatic test_decode_b();
    int n;
    n = 0;
    while (!(y_b === 10'd479 && x_b === 4'd5) && n < 6000) begin @(negedge clk); n++; end
    checks++;
    if (crow_b !== 6'd29 || gy_b !== 4'd15) begin
      errors++; $display("FAIL decode_y479 got row=%0d gy=%0d want 29 15", crow_b, gy_b);
    end
    checks++;
    if (ccol_b !== 1'b0 || gx_b !== 3'd5 || act_b !== 1'b1) begin
      errors++; $display("FAIL decode_b_x5 got col=%0d gx=%0d act=%b want 0 5 1", ccol_b, gx_b, act_b);
    end
    n = 0;
    while (y_b !== 10'd480 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (act_b !== 1'b0) begin
      errors++; $display("FAIL active_y480 got=%b want=0", act_b);
    end
  endtask

  task automatic test_stb_const_b();
    int lows, lines;
    lows = 0; lines = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (stb_b !== 1'b1) lows++;
      if (ls_b === 1'b1) lines++;
    end
    checks++;
    if (lows !== 0 || lines !== 2) begin
      errors++; $display("FAIL stb_div1 got gaps=%0d lines=%0d want 0 2", lows, lines);
    end
  endtask

  task automatic test_vsync_b();
    int n, m, h, frames;
    n = 0;
    while (!fs_b && n < 6000) begin @(negedge clk); n++; end
    n = 0;
    while (n < 6000) begin
      @(posedge clk); #1; n++;
      if (!vs_b) break;
    end
    checks++;
    if (n !== 490 * 11 + 2 + 1) begin
      errors++; $display("FAIL vs_fall got=%0d want=%0d", n, 490 * 11 + 2 + 1);
    end
    m = 0; frames = 0;
    while (m < 100) begin
      @(posedge clk); #1; m++;
      if (fs_b) frames++;
      if (vs_b) break;
    end
    checks++;
    if (m !== 22) begin
      errors++; $display("FAIL vs_low got=%0d want=22", m);
    end
    h = 0;
    while (h < 6000) begin
      @(posedge clk); #1; h++;
      if (fs_b) frames++;
      if (!vs_b) break;
    end
    checks++;
    if (m + h !== 5775) begin
      errors++; $display("FAIL vs_period got=%0d want=5775", m + h);
    end
    checks++;
    if (frames !== 1) begin
      errors++; $display("FAIL frame_start_count got=%0d want=1", frames);
    end
  endtask

  task automatic test_colour_frame_b();
    int n, cnt_on, cnt_off;
    n = 0;
    while (!fs_b && n < 6000) begin @(negedge clk); n++; end
    cnt_on = 0; cnt_off = 0;
    for (int i = 0; i < 5775; i++) begin
      if (r_b === 4'hF) cnt_on++;
      if (r_b === 4'h0) cnt_off++;
      @(negedge clk);
    end
    checks++;
    if (cnt_on !== 480 * 8 || cnt_off !== 5775 - 480 * 8) begin
      errors++; $display("FAIL frame_red got on=%0d off=%0d want 3840 1935", cnt_on, cnt_off);
    end
  endtask

  task automatic test_reset_midline();
    int n;
    n = 0;
    while (x_a !== 10'd100 && n < 3300) begin @(negedge clk); n++; end
    #2 rst_btn = 1'b0;
    #1;
    checks++;
    if (x_a !== 10'd0 || hs_a !== 1'b1 || r_a !== 4'h0 || stb_a !== 1'b0) begin
      errors++; $display("FAIL async_reset got x=%0d hs=%b r=%h stb=%b want 0 1 0 0", x_a, hs_a, r_a, stb_a);
    end
    @(negedge clk);
    rst_btn = 1'b1;
    n = 0;
    while (!stb_a && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (stb_a !== 1'b1 || fs_a !== 1'b1 || y_a !== 10'd0) begin
      errors++; $display("FAIL reset_restart got stb=%b fs=%b y=%0d want 1 1 0", stb_a, fs_a, y_a);
    end
  endtask

  initial begin
    test_reset();
    test_first_strobe();
    test_hsync();
    test_colour_line();
    test_decode_a();
    test_enable(300);
    test_enable(700);
    test_decode_b();
    test_stb_const_b();
    test_vsync_b();
    test_colour_frame_b();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
